oam_dma_ctrl: RTL
=================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have port clk4, input, 1: the sole clock; all state changes on its rising edge; one clk4 period is one DMA slot.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port cpu_wr, input, 1: CPU write strobe, valid for one clk4 cycle.
REQ-004 SHALL have port cpu_rd, input, 1: CPU read strobe.
REQ-005 SHALL have port ff46, input, 1: register select, high when the CPU address is 0xFF46.
REQ-006 SHALL have port d_in, input, 8: CPU write data.
REQ-007 SHALL have port d_out, output, 8: FF46 readback value.
REQ-008 SHALL have port d_out_en, output, 1: high when cpu_rd & ff46; drives d_out onto the internal bus.
REQ-009 SHALL have port dma_din, input, 8: source read data, sampled at the end of a READ slot.
REQ-010 SHALL have port dma_a, output, 16: source address.
REQ-011 SHALL have port oam_a, output, 8: OAM destination index, 0..159.
REQ-012 SHALL have port oam_dout, output, 8: byte to write into OAM.
REQ-013 SHALL have port oam_dma_wr, output, 1: OAM write strobe.
REQ-014 SHALL have port dma_run, output, 1: transfer in progress; the bus is owned by the DMA.
REQ-015 SHALL have port vram_to_oam, output, 1: dma_run and source in 0x8000-0x9FFF.
REQ-016 SHALL have port dma_addr_ext, output, 1: dma_run and source outside 0x8000-0x9FFF (external bus).

Function
REQ-017 SHALL implement states IDLE, START, READ, WRITE.
REQ-018 SHALL load d_in into an 8-bit src_hi register on cpu_wr & ff46, in any state.
REQ-019 SHALL force the state to START on the same write, from any state, and clear the byte counter idx to 0.
REQ-020 SHALL move from START to READ after exactly one clk4 cycle.
REQ-021 SHALL, in READ, drive dma_a = {src_hi, idx}, latch dma_din into the data latch at the clock edge, and go to WRITE.
REQ-022 SHALL, in WRITE, assert oam_dma_wr for exactly one cycle with oam_a = idx and oam_dout = the data latch.
REQ-023 SHALL, in WRITE, go to IDLE when idx = 159; otherwise it SHALL increment idx and go to READ.
REQ-024 SHALL make a transfer take 1 + 320 cycles from the write to the return to IDLE; the final oam_dma_wr occurs in the last cycle.
REQ-025 SHALL hold idx within 8 bits and never let it exceed 159; no wrap occurs.
REQ-026 SHALL assert dma_run in READ and WRITE only, and deassert it in IDLE and START.
REQ-027 SHALL drive dma_a to 0 and oam_dma_wr to 0 when in IDLE or START.
REQ-028 SHALL make d_out = src_hi at all times; readback works during a transfer.
REQ-029 SHALL, on a restart during READ or WRITE, perform no oam_dma_wr in the restart cycle; the new transfer begins at idx 0 using the new src_hi.
REQ-030 SHALL derive vram_to_oam and dma_addr_ext combinationally from the effective dma_a, and keep them mutually exclusive.

Reset
REQ-031 SHALL, while reset is high, asynchronously force state IDLE, idx 0, src_hi 0x00 and the data latch 0x00.
REQ-032 SHALL, while reset is high, hold every output at 0 (d_out = 0x00).
REQ-033 SHALL, when reset is asserted mid-transfer, abort the transfer with no further OAM writes.
REQ-034 SHALL leave IDLE after reset only on a new FF46 write.

Configuration
REQ-035 SHALL, with DMA_ECHO_REMAP_EN defined, map src_hi values 0xE0-0xFF to source addresses 0xC000-0xDFFF by clearing dma_a[13]; src_hi and d_out keep the written value.
REQ-036 SHALL, without DMA_ECHO_REMAP_EN, drive dma_a = {src_hi, idx} unmodified for every src_hi value.

Verification
REQ-037 SHALL cover: write 0xC1 to FF46 with dma_din = low address byte -> oam_dma_wr pulses at cycles 3,5,...,321; OAM[i] = i for i = 0..159; dma_run low at cycle 322.
REQ-038 SHALL cover: write 0x80 -> vram_to_oam = 1 and dma_addr_ext = 0 throughout the run; dma_a spans 0x8000-0x809F.
REQ-039 SHALL cover: write 0xC0, then write 0xD0 at idx 50 -> no oam_dma_wr in the restart cycle; the next write goes to oam_a 0 from 0xD000; d_out = 0xD0.
REQ-040 SHALL cover: write 0xFE -> with DMA_ECHO_REMAP_EN the first dma_a is 0xDE00; without it the first dma_a is 0xFE00; d_out = 0xFE in both cases.
REQ-041 SHALL cover: assert reset at idx 80 -> all outputs go to 0 immediately; no oam_dma_wr until the next FF46 write.
REQ-042 SHALL cover: cpu_rd & ff46 during a transfer -> d_out_en = 1 and d_out = src_hi; transfer timing is unchanged.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA: an FF46 write copies 160 bytes from {src_hi,00..9F} into OAM, one byte per READ/WRITE slot pair, 321 cycles.
// No backpressure: the run is fixed-rate, and a new FF46 write restarts it at once. DMA_ECHO_REMAP_EN folds E0-FF sources onto C0-DF.
module oam_dma_ctrl (
    input  logic        clk4,
    input  logic        reset,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        ff46,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_out_en,
    input  logic [7:0]  dma_din,
    output logic [15:0] dma_a,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_dout,
    output logic        oam_dma_wr,
    output logic        dma_run,
    output logic        vram_to_oam,
    output logic        dma_addr_ext
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'd159;

    state_t     r_state;
    logic [7:0] r_src_hi;
    logic [7:0] r_idx;
    logic [7:0] r_data;

    logic       w_restart;
    logic       w_run;
    logic [7:0] w_src_eff;

    assign w_restart = cpu_wr & ff46;
    assign w_run     = (r_state == READ) || (r_state == WRITE);

`ifdef DMA_ECHO_REMAP_EN
    // Echo RAM E000-FFFF mirrors C000-DFFF; only the bus address is folded, the register keeps the written byte.
    assign w_src_eff = (r_src_hi[7:5] == 3'b111) ? {r_src_hi[7:6], 1'b0, r_src_hi[4:0]} : r_src_hi;
`else
    assign w_src_eff = r_src_hi;
`endif

    always_ff @(posedge clk4 or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_src_hi <= 8'h00;
            r_idx    <= 8'h00;
            r_data   <= 8'h00;
        end else if (w_restart) begin
            r_src_hi <= d_in;
            r_idx    <= 8'h00;
            r_state  <= START;
        end else begin
            case (r_state)
                IDLE:  r_state <= IDLE;
                START: r_state <= READ;
                READ: begin
                    r_data  <= dma_din;
                    r_state <= WRITE;
                end
                WRITE: begin
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= 8'h00;
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= READ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dma_run      = w_run;
    assign dma_a        = w_run ? {w_src_eff, r_idx} : 16'h0000;
    // A restart landing on a WRITE slot kills that write; the new run starts clean at idx 0.
    assign oam_dma_wr   = (r_state == WRITE) & ~w_restart;
    assign oam_a        = (r_state == WRITE) ? r_idx  : 8'h00;
    assign oam_dout     = (r_state == WRITE) ? r_data : 8'h00;
    assign vram_to_oam  = w_run & (dma_a[15:13] == 3'b100);
    assign dma_addr_ext = w_run & (dma_a[15:13] != 3'b100);
    assign d_out        = r_src_hi;
    assign d_out_en     = cpu_rd & ff46 & ~reset;

endmodule
